// File: rtl/temp_display_ctrl.sv
// Binary sample -> hundreds/tens/ones digit codes by repeated subtraction. Each digit commits on a frame boundary, h+t+2 cycles after the sample is accepted.
// One sample is handled at a time; temp_valid outside IDLE is dropped and flagged on overrun. Digits fall back to STALE_CODE when too many frames pass without a commit.
module temp_display_ctrl #(
  parameter int         IN_W         = 10,
  parameter int         MAX_VALUE    = 999,
  parameter int         STALE_FRAMES = 60,
  parameter logic [3:0] STALE_CODE   = 4'd10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] temp_in,
  input  logic            temp_valid,
  input  logic            frame_start,
  output logic            in_ready,
  output logic            overrun,
  output logic            stale,
  output logic [3:0]      temp_value_100,
  output logic [3:0]      temp_value_10,
  output logic [3:0]      temp_value_1
);

  localparam int              CNT_W    = (STALE_FRAMES > 0) ? $clog2(STALE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;
  localparam logic [IN_W-1:0]  MAX_V    = IN_W'(MAX_VALUE);
  localparam logic [IN_W-1:0]  C100     = IN_W'(100);
  localparam logic [IN_W-1:0]  C10      = IN_W'(10);

  typedef enum logic [1:0] {IDLE, CONV_H, CONV_T, WAIT_FRAME} state_t;

  state_t           state_q;
  logic [IN_W-1:0]  rem_q;
  logic [3:0]       h_q, t_q, o_q;
  logic [3:0]       dig100_q, dig10_q, dig1_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             overrun_q;
  logic             stale_q;
  logic             commit;
  logic             frame_counts;

  assign commit       = (state_q == WAIT_FRAME) && frame_start;
  assign frame_counts = frame_start && !commit && (STALE_FRAMES != 0) && (frame_cnt_q != CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      h_q         <= '0;
      t_q         <= '0;
      o_q         <= '0;
      dig100_q    <= STALE_CODE;
      dig10_q     <= STALE_CODE;
      dig1_q      <= STALE_CODE;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      stale_q     <= 1'b1;
    end else begin
      overrun_q <= temp_valid && (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (temp_valid) begin
            rem_q   <= (temp_in > MAX_V) ? MAX_V : temp_in;
            h_q     <= '0;
            t_q     <= '0;
            state_q <= CONV_H;
          end
        end
        CONV_H: begin
          if (rem_q >= C100) begin
            rem_q <= rem_q - C100;
            h_q   <= h_q + 4'd1;
          end else begin
            state_q <= CONV_T;
          end
        end
        CONV_T: begin
          if (rem_q >= C10) begin
            rem_q <= rem_q - C10;
            t_q   <= t_q + 4'd1;
          end else begin
            o_q     <= rem_q[3:0];
            state_q <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            dig100_q <= h_q;
            dig10_q  <= t_q;
            dig1_q   <= o_q;
            stale_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Stale timer: a commit clears it, any other frame advances it (saturating).
      if (commit) begin
        frame_cnt_q <= '0;
      end else if (frame_counts) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
        if (frame_cnt_q == CNT_LAST) begin
          dig100_q <= STALE_CODE;
          dig10_q  <= STALE_CODE;
          dig1_q   <= STALE_CODE;
          stale_q  <= 1'b1;
        end
      end
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign overrun        = overrun_q;
  assign stale          = stale_q;
  assign temp_value_100 = dig100_q;
  assign temp_value_10  = dig10_q;
  assign temp_value_1   = dig1_q;

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Directed bench for temp_display_ctrl with a short stale window (3 frames).
module tb_temp_display_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] temp_in = '0;
  logic       temp_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       in_ready, overrun, stale;
  logic [3:0] temp_value_100, temp_value_10, temp_value_1;

  int n_tests = 0;
  int n_fail  = 0;

  temp_display_ctrl #(
    .IN_W(10), .MAX_VALUE(999), .STALE_FRAMES(3), .STALE_CODE(4'd10)
  ) dut (
    .clk(clk), .reset(reset), .temp_in(temp_in), .temp_valid(temp_valid),
    .frame_start(frame_start), .in_ready(in_ready), .overrun(overrun), .stale(stale),
    .temp_value_100(temp_value_100), .temp_value_10(temp_value_10), .temp_value_1(temp_value_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [9:0] v);
    temp_in    = v;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_digits(input string tag, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    check({tag, "_100"}, 32'(temp_value_100), 32'(h));
    check({tag, "_10"},  32'(temp_value_10),  32'(t));
    check({tag, "_1"},   32'(temp_value_1),   32'(o));
  endtask

  initial begin
    // Reset values
    wait_n(2);
    check_digits("rst", 4'd10, 4'd10, 4'd10);
    check("rst_stale", 32'(stale), 1);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_overrun", 32'(overrun), 0);
    #2 reset = 1'b0;
    tick();

    // 725: WAIT_FRAME entered 11 edges after accept; a frame one edge early must not commit
    send(10'd725);
    check("725_busy", 32'(in_ready), 0);
    wait_n(10);
    frame();
    check("725_early_frame", 32'(temp_value_100), 10);
    check("725_early_stale", 32'(stale), 1);
    frame();
    check_digits("725", 4'd7, 4'd2, 4'd5);
    check("725_stale", 32'(stale), 0);
    check("725_idle", 32'(in_ready), 1);

    // Clamp and zero (latency 2)
    send(10'd1023);
    wait_n(22);
    frame();
    check_digits("1023", 4'd9, 4'd9, 4'd9);
    send(10'd0);
    wait_n(1);
    frame();
    check("zero_early_frame", 32'(temp_value_1), 9);
    check("zero_busy", 32'(in_ready), 0);
    frame();
    check_digits("zero", 4'd0, 4'd0, 4'd0);

    // Overrun: second sample while busy is dropped
    send(10'd345);
    wait_n(2);
    temp_in    = 10'd111;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    check("ovr_pulse", 32'(overrun), 1);
    tick();
    check("ovr_clear", 32'(overrun), 0);
    wait_n(10);
    frame();
    check_digits("345", 4'd3, 4'd4, 4'd5);
    check("345_idle", 32'(in_ready), 1);

    // Stale: two idle frames, then a sample accepted together with the third frame
    frame();
    check("stale_f1", 32'(stale), 0);
    frame();
    check("stale_f2", 32'(stale), 0);
    temp_in     = 10'd42;
    temp_valid  = 1'b1;
    frame_start = 1'b1;
    tick();
    temp_valid  = 1'b0;
    frame_start = 1'b0;
    check("stale_f3", 32'(stale), 1);
    check("stale_f3_dig", 32'(temp_value_10), 10);
    check("stale_f3_accepted", 32'(in_ready), 0);
    wait_n(8);
    frame();
    check_digits("42", 4'd0, 4'd4, 4'd2);
    check("42_stale", 32'(stale), 0);
    // Commit zeroed the counter: stale only after three further frames
    frame();
    frame();
    check("cnt_reset_f2", 32'(stale), 0);
    frame();
    check("cnt_reset_f3", 32'(stale), 1);
    check("cnt_reset_dig", 32'(temp_value_1), 10);
    frame();
    check("stale_sat", 32'(stale), 1);

    // Reset mid CONV_T
    send(10'd999);
    wait_n(22);
    frame();
    check_digits("999", 4'd9, 4'd9, 4'd9);
    send(10'd512);
    wait_n(6);
    #2 reset = 1'b1;
    #1;
    check_digits("async_rst", 4'd10, 4'd10, 4'd10);
    check("async_rst_ready", 32'(in_ready), 1);
    check("async_rst_stale", 32'(stale), 1);
    #1 reset = 1'b0;
    tick();
    send(10'd64);
    wait_n(9);
    frame();
    check_digits("64", 4'd0, 4'd6, 4'd4);
    check("64_stale", 32'(stale), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
